// File: rtl/oneshot_ctrl_pkg.sv
// oneshot_ctrl_pkg: shared state encoding and default sizes for the one-shot stop sequencer
package oneshot_ctrl_pkg;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_SETTLE = 15;
    localparam int DEF_STAT_W = 16;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_RUN,
        ST_DRAIN,
        ST_GRANT,
        ST_HOLDOFF
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: loadable count-down timer with zero flag; load value N gives N+1 cycles to zero
module dwell_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // load wins; otherwise count down and rest at zero
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);

    assign zero = cnt == '0;

endmodule

// File: rtl/oneshot_stop_ctrl.sv
// oneshot_stop_ctrl: trig_stop sequencer with power-up settle, config freeze handshake and stop-cycle stats
module oneshot_stop_ctrl
    import oneshot_ctrl_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int SETTLE = DEF_SETTLE,
    parameter int STAT_W = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_stop,
    input  logic              cfg_req,
    output logic              cfg_gnt,
    input  logic [CNT_W-1:0]  drain_cyc,
    input  logic [CNT_W-1:0]  holdoff_cyc,
    output logic              trig_stop,
    output logic              busy,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stop_cnt
);

    state_t           state, next_state;
    logic             dwell_zero;
    logic             load;
    logic [CNT_W-1:0] load_val;

    // every state change reloads the dwell; only SETTLE, DRAIN and HOLDOFF consume it
    assign load     = next_state != state;
    assign load_val = next_state == ST_HOLDOFF ? holdoff_cyc :
                      next_state == ST_SETTLE  ? CNT_W'(SETTLE) : drain_cyc;

    dwell_timer #(
        .CNT_W  (CNT_W),
        .RST_VAL(CNT_W'(SETTLE))
    ) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(load_val),
        .zero    (dwell_zero)
    );

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= ST_SETTLE;
        else
            state <= next_state;

    // next-state logic; a dropped request in DRAIN aborts even on the last dwell cycle
    always_comb begin
        next_state = ST_SETTLE;
        case (state)
            ST_SETTLE:  next_state = dwell_zero ? (cfg_req ? ST_DRAIN : ST_RUN) : ST_SETTLE;
            ST_RUN:     next_state = cfg_req ? ST_DRAIN : ST_RUN;
            ST_DRAIN:   next_state = !cfg_req ? ST_RUN : dwell_zero ? ST_GRANT : ST_DRAIN;
            ST_GRANT:   next_state = cfg_req ? ST_GRANT : ST_HOLDOFF;
            ST_HOLDOFF: next_state = dwell_zero ? (cfg_req ? ST_DRAIN : ST_RUN) : ST_HOLDOFF;
            default:    next_state = ST_SETTLE;
        endcase
    end

    // outputs registered from next_state so they match the state on entry
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            trig_stop <= 1'b1;
            busy      <= 1'b1;
            cfg_gnt   <= 1'b0;
        end else begin
            trig_stop <= next_state == ST_RUN ? ext_stop : 1'b1;
            busy      <= next_state != ST_RUN;
            cfg_gnt   <= next_state == ST_GRANT;
        end

    // saturating count of frozen cycles; clear has priority
    always_ff @(posedge clk or posedge rst)
        if (rst)
            stop_cnt <= '0;
        else if (stat_clr)
            stop_cnt <= '0;
        else if (trig_stop && !(&stop_cnt))
            stop_cnt <= stop_cnt + STAT_W'(1);

endmodule
